// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants, the stereo sample type and the frame builder
//               used by the I2S frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int FRAME_BITS  = 64;
  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 16;
  localparam int LEFT_MSB_K  = 1;
  localparam int RIGHT_MSB_K = 33;

  typedef struct packed {
    logic signed [SAMPLE_BITS-1:0] left;
    logic signed [SAMPLE_BITS-1:0] right;
  } stereo_sample_t;

  // Frame image in transmit order (bit 63 goes out at k = 0). The leading
  // zero is the one-bit I2S delay, so each slot's MSB lands at k = 1 / 33.
  function automatic logic [FRAME_BITS-1:0] build_frame(input stereo_sample_t s);
    return {1'b0, s.left, {(SLOT_BITS-SAMPLE_BITS){1'b0}},
            s.right, {(SLOT_BITS-SAMPLE_BITS-1){1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_frame_tx_if
// Description : Stereo sample valid/ready bus into the I2S transmitter.
//               master : sample producer (mixer)  - drives left/right/valid
//               slave  : i2s_frame_tx             - drives in_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_frame_tx_if;

  logic signed [15:0] left_in;
  logic signed [15:0] right_in;
  logic               in_valid;
  logic               in_ready;

  modport master (output left_in, output right_in, output in_valid, input in_ready);
  modport slave  (input left_in, input right_in, input in_valid, output in_ready);

endinterface
`default_nettype wire

// File: rtl/sigma_delta_dac.sv
`default_nettype none
// ============================================================================
// Module      : sigma_delta_dac
// Description : First-order sigma-delta modulator for one audio channel.
//               The pulse density of dac equals the offset-binary sample
//               divided by 65536.
// Ports       : clk     - audio clock
//               reset_n - asynchronous active-low reset
//               sample  - signed 16-bit sample (held for the whole frame)
//               dac     - 1-bit bitstream for the RC-filtered GPIO pin
// Revision    : 1.0 - initial release
// ============================================================================
module sigma_delta_dac (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic signed [15:0] sample,
  output logic                    dac
);

  logic [16:0] r_acc;
  logic [15:0] w_u;

  // Flipping the sign bit maps -32768..32767 onto 0..65535.
  assign w_u = sample ^ 16'h8000;

  // The carry out of the 16-bit accumulator is the output bit; it is dropped
  // before the next add so only the residue is carried forward.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= 17'd0;
    end else begin
      r_acc <= {1'b0, r_acc[15:0]} + {1'b0, w_u};
    end
  end

  assign dac = r_acc[16];

endmodule
`default_nettype wire

// File: rtl/i2s_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_frame_tx
// Description : Serializes a stereo pair into a 64-bit I2S frame (BCLK, LRCLK,
//               DATA) with bit clock derived fractionally from clk. One-deep
//               holding register on the input; underrun pulses when a frame
//               starts without a fresh pair (the previous pair is repeated).
// Macro       : I2S_SIGMA_DELTA_EN - adds per-channel sigma-delta bitstreams
//               on dac_l / dac_r; without it both outputs are tied low.
// Parameters  : CLK_RATE    - clk frequency in Hz
//               SAMPLE_RATE - frame rate in Hz (CLK_RATE >= 256*SAMPLE_RATE)
// Ports       : clk, reset_n        - clock, asynchronous active-low reset
//               bus (slave)         - left_in/right_in/in_valid/in_ready
//               i2s_bclk/lrclk/data - codec serial pins
//               underrun            - one-clk pulse on a frame with no new pair
//               dac_l, dac_r        - sigma-delta bitstreams
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_tx
  import i2s_pkg::*;
#(
  parameter int CLK_RATE    = 50000000,
  parameter int SAMPLE_RATE = 48000
) (
  input  wire logic      clk,
  input  wire logic      reset_n,
  i2s_frame_tx_if.slave  bus,
  output logic           i2s_bclk,
  output logic           i2s_lrclk,
  output logic           i2s_data,
  output logic           underrun,
  output logic           dac_l,
  output logic           dac_r
);

  // Two bclk edges per bit, 64 bits per frame: 128 ticks per frame.
  localparam logic [32:0] C_INC  = 33'(128 * SAMPLE_RATE);
  localparam logic [32:0] C_RATE = 33'(CLK_RATE);

  logic [31:0]             r_ph;
  logic                    r_bclk;
  logic [5:0]              r_k;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_data;
  logic                    r_lrclk;
  logic                    r_underrun;
  logic                    r_ready;
  stereo_sample_t          r_hold;
  stereo_sample_t          r_last;

  logic [32:0]             w_sum;
  logic [31:0]             w_wrap;
  logic                    w_tick;
  logic                    w_fall;
  logic                    w_load;
  logic [5:0]              w_k_next;
  logic                    w_accept;
  stereo_sample_t          w_src;
  logic [FRAME_BITS-1:0]   w_frame;

  // Phase accumulator: the 33-bit sum cannot overflow, and the wrapped value
  // is always below CLK_RATE so the low 32 bits are exact.
  assign w_sum    = {1'b0, r_ph} + C_INC;
  assign w_wrap   = w_sum[31:0] - C_RATE[31:0];
  assign w_tick   = (w_sum >= C_RATE);

  assign w_fall   = w_tick & r_bclk;
  assign w_load   = w_fall & (r_k == 6'(FRAME_BITS - 1));
  assign w_k_next = r_k + 6'd1;
  assign w_accept = bus.in_valid & r_ready;

  // An empty holding register means the previous pair is repeated.
  assign w_src    = r_ready ? r_last : r_hold;
  assign w_frame  = build_frame(w_src);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ph       <= 32'd0;
      r_bclk     <= 1'b0;
      r_k        <= 6'(FRAME_BITS - 1);
      r_shift    <= '0;
      r_data     <= 1'b0;
      r_lrclk    <= 1'b1;
      r_underrun <= 1'b0;
      r_ready    <= 1'b1;
      r_hold     <= '0;
      r_last     <= '0;
    end else begin
      r_ph       <= w_tick ? w_wrap : w_sum[31:0];
      r_underrun <= 1'b0;

      if (w_tick) begin
        r_bclk <= ~r_bclk;
      end

      // Data, lrclk and k all advance together on the bclk falling edge.
      if (w_fall) begin
        r_k     <= w_k_next;
        r_lrclk <= w_k_next[5];
        if (w_load) begin
          r_data  <= w_frame[FRAME_BITS-1];
          r_shift <= {w_frame[FRAME_BITS-2:0], 1'b0};
          if (r_ready) begin
            r_underrun <= 1'b1;
          end else begin
            r_last <= r_hold;
          end
        end else begin
          r_data  <= r_shift[FRAME_BITS-1];
          r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
      end

      // Draining the register (needs it full) and accepting (needs it empty)
      // can never coincide, so a same-clk accept lands for the next frame.
      if (w_load && !r_ready) begin
        r_ready <= 1'b1;
      end
      if (w_accept) begin
        r_hold  <= {bus.left_in, bus.right_in};
        r_ready <= 1'b0;
      end
    end
  end

  assign i2s_bclk     = r_bclk;
  assign i2s_lrclk    = r_lrclk;
  assign i2s_data     = r_data;
  assign underrun     = r_underrun;
  assign bus.in_ready = r_ready;

`ifdef I2S_SIGMA_DELTA_EN
  sigma_delta_dac u_sd_l (
    .clk     (clk),
    .reset_n (reset_n),
    .sample  (r_last.left),
    .dac     (dac_l)
  );

  sigma_delta_dac u_sd_r (
    .clk     (clk),
    .reset_n (reset_n),
    .sample  (r_last.right),
    .dac     (dac_r)
  );
`else
  assign dac_l = 1'b0;
  assign dac_r = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_frame_tx
// Description : Scoreboard bench for i2s_frame_tx. The driver logs every
//               accepted pair; at each frame start the monitor decides which
//               pair the frame must carry (or that it is an underrun), queues
//               the expected 64-bit frame, and compares it once all 64 bits
//               have been sampled on bclk rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_frame_tx;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  i2s_frame_tx_if bus ();
  logic i2s_bclk, i2s_lrclk, i2s_data, underrun, dac_l, dac_r;

  i2s_frame_tx #(
    .CLK_RATE    (50000000),
    .SAMPLE_RATE (48000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_data  (i2s_data),
    .underrun  (underrun),
    .dac_l     (dac_l),
    .dac_r     (dac_r)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Posedge count; stable when read on the falling edge.
  int e = 0;
  always @(posedge clk) e <= e + 1;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          edge_n;
  } acc_t;

  acc_t        acc_q[$];
  logic [63:0] exp_q[$];
  int          load_edges[$];

  logic        prev_bclk = 1'b0;
  logic        prev_lr   = 1'b1;
  int          last_chg  = -1;
  bit          started   = 1'b0;
  int          rise_cnt  = 0;
  int          load_count = 0;
  int          last_load_edge = 0;
  logic [63:0] cap_d, cap_lr, exp_f;
  logic [15:0] last_l = 16'h0;
  logic [15:0] last_r = 16'h0;
  logic        exp_ur;
  acc_t        item;

  // Monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      acc_q.delete();
      exp_q.delete();
      load_edges.delete();
      started   = 1'b0;
      rise_cnt  = 0;
      last_l    = 16'h0;
      last_r    = 16'h0;
      last_chg  = -1;
      prev_bclk = i2s_bclk;
      prev_lr   = i2s_lrclk;
    end else begin
      if (i2s_bclk !== prev_bclk) begin
        if (last_chg >= 0) chk_rng("bclk_half_period", e - last_chg, 8, 9);
        last_chg = e;
      end

      if (i2s_bclk && !prev_bclk && started && rise_cnt < 64) begin
        cap_d  = {cap_d[62:0], i2s_data};
        cap_lr = {cap_lr[62:0], i2s_lrclk};
        rise_cnt++;
        if (rise_cnt == 64) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %h expected none", cap_d);
          end else begin
            exp_f = exp_q.pop_front();
            chk("frame_data", cap_d, exp_f);
            chk("frame_lrclk", cap_lr, 64'h0000_0000_FFFF_FFFF);
          end
        end
      end

      if (prev_lr && !i2s_lrclk) begin
        if (started) chk("bclk_rises_per_frame", 64'(rise_cnt), 64'd64);
        started        = 1'b1;
        rise_cnt       = 0;
        load_count++;
        last_load_edge = e;
        load_edges.push_back(e);
        if (load_edges.size() >= 4)
          chk_rng("three_frame_span", e - load_edges[load_edges.size()-4], 3124, 3126);
        if (acc_q.size() > 0 && acc_q[0].edge_n < e) begin
          item   = acc_q.pop_front();
          last_l = item.l;
          last_r = item.r;
          exp_ur = 1'b0;
        end else begin
          exp_ur = 1'b1;
        end
        chk("underrun_at_load", 64'(underrun), 64'(exp_ur));
        exp_q.push_back({1'b0, last_l, 16'h0000, last_r, 15'h0000});
      end else begin
        chk("underrun_idle", 64'(underrun), 64'd0);
      end

`ifndef I2S_SIGMA_DELTA_EN
      chk("dac_tied_low", 64'({dac_l, dac_r}), 64'd0);
`endif

      prev_bclk = i2s_bclk;
      prev_lr   = i2s_lrclk;
    end
  end

  // Call on a falling edge. Holds in_valid until accepted, logs the accept
  // edge for the monitor and returns it.
  task automatic send(input logic [15:0] l, input logic [15:0] r, output int ae);
    int   t = 0;
    acc_t a;
    bus.left_in  = l;
    bus.right_in = r;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ae = -1;
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 3000 clk");
    end else begin
      ae       = e + 1;
      a.l      = l;
      a.r      = r;
      a.edge_n = ae;
      acc_q.push_back(a);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (ae >= 0) chk("in_ready_drop", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_loads(input int n);
    int t = 0;
    while (load_count < n && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (load_count < n) begin
      checks++;
      errors++;
      $display("FAIL wait_loads_timeout: got %0d loads expected %0d", load_count, n);
    end
  endtask

  int ae, ae2;

  initial begin
    bus.in_valid = 1'b0;
    bus.left_in  = 16'h0;
    bus.right_in = 16'h0;

    repeat (3) @(negedge clk);
    chk("rst_bclk",     64'(i2s_bclk),     64'd0);
    chk("rst_lrclk",    64'(i2s_lrclk),    64'd1);
    chk("rst_data",     64'(i2s_data),     64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_underrun", 64'(underrun),     64'd0);
    chk("rst_dac",      64'({dac_l, dac_r}), 64'd0);
    reset_n = 1'b1;

    // Reference pattern into the very first frame.
    send(16'hA5C3, 16'h1234, ae);
    wait_loads(1);

    // Two pairs with valid held high: the second waits for the next load.
    send(16'h1111, 16'h2222, ae);
    send(16'h8001, 16'h7FFE, ae2);
    repeat (10) @(negedge clk);
    chk("second_accept_after_load", 64'(ae2), 64'(last_load_edge + 1));

    // Starve the input: underruns with the last pair repeated.
    wait_loads(load_count + 4);

    // Reset mid-frame with a pair pending in the holding register.
    send(16'hDEAD, 16'hBEEF, ae);
    begin
      int t = 0;
      while (rise_cnt != 20 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (rise_cnt != 20) begin
        checks++;
        errors++;
        $display("FAIL wait_k20_timeout: got rise_cnt=%0d expected 20", rise_cnt);
      end
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_bclk",     64'(i2s_bclk),     64'd0);
    chk("midrst_lrclk",    64'(i2s_lrclk),    64'd1);
    chk("midrst_data",     64'(i2s_data),     64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Frames after release must carry zeros (pending pair discarded).
    wait_loads(load_count + 2);
    send(16'h0001, 16'hFFFF, ae);
    wait_loads(load_count + 2);

`ifdef I2S_SIGMA_DELTA_EN
    send(16'h4000, 16'h0000, ae);
    wait_loads(load_count + 2);
    begin
      int ones = 0;
      for (int i = 0; i < 65536; i++) begin
        @(negedge clk);
        if (dac_l) ones++;
      end
      chk_rng("sd_density_l", ones, 49151, 49153);
    end
`endif

    wait_loads(load_count + 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
